lsu_wb: RTL and testbench
=========================

LSU_WB -- requirements
Module: lsu_wb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning bus/data width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte address width.
REQ-003 SHALL have parameter MAX_RETRY, default 3, meaning the number of re-issues allowed after rty_i.
REQ-004 SHALL have parameter TIMEOUT, default 255, meaning the number of cycles in REQ without a response before a fault.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock; all logic SHALL use its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port req_i, input, 1 bit: core request strobe, sampled in IDLE only.
REQ-008 SHALL have port we_i, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port size_i, input, 2 bits: 0 byte, 1 half, 2 word, 3 dword.
REQ-010 SHALL have port unsigned_i, input, 1 bit: zero-extend the load result when set.
REQ-011 SHALL have ports addr_i (input, ADDR_WIDTH) and wdata_i (input, DATA_WIDTH): request address and store data, right-aligned.
REQ-012 SHALL have port abort_i, input, 1 bit: interrupt-pending cancel request.
REQ-013 SHALL have ports busy_o (output, 1 bit) and done_o (output, 1 bit, one-cycle pulse).
REQ-014 SHALL have ports rdata_o (output, DATA_WIDTH), fault_o (output, 1 bit) and cause_o (output, 3 bits).
REQ-015 SHALL have Wishbone master ports cyc_o, stb_o, we_o (output, 1 bit each); adr_o (output, ADDR_WIDTH); sel_o (output, DATA_WIDTH/8); dat_o (output, DATA_WIDTH); dat_i (input, DATA_WIDTH); ack_i, err_i, rty_i (input, 1 bit each).

Function
REQ-016 SHALL implement the states IDLE, REQ, BACKOFF and DONE.
REQ-017 In IDLE, req_i=1 SHALL latch all request inputs, assert busy_o and enter REQ; cyc_o, stb_o, adr_o, sel_o, we_o and dat_o SHALL be registered and valid on the next cycle.
REQ-018 adr_o SHALL be addr_i with its low log2(DATA_WIDTH/8) bits cleared; sel_o SHALL be the size mask shifted by the byte offset; dat_o SHALL be wdata_i shifted by 8*offset.
REQ-019 A misaligned request (half at an odd address, word not 4-aligned, dword not 8-aligned) SHALL skip the bus and go to DONE with cause 1.
REQ-020 size 3 with DATA_WIDTH=32 SHALL skip the bus and go to DONE with cause 6.
REQ-021 In REQ, on ack_i, dat_i SHALL be captured, cyc_o/stb_o SHALL be dropped and the block SHALL enter DONE with no fault.
REQ-022 Priority on simultaneous responses SHALL be ack_i > err_i > rty_i.
REQ-023 err_i SHALL cause DONE with cause 2.
REQ-024 rty_i SHALL enter BACKOFF (cyc_o=0 for exactly 1 cycle), then re-issue in REQ; the rty_i that arrives after MAX_RETRY re-issues SHALL cause DONE with cause 4.
REQ-025 A timeout counter SHALL clear on each REQ entry and increment each REQ cycle without a response; reaching TIMEOUT SHALL cause DONE with cause 3.
REQ-026 abort_i SHALL be honoured only in REQ/BACKOFF before any ack_i: it SHALL drop cyc_o and go to DONE with cause 5; abort_i in IDLE or in an ack cycle SHALL be ignored.
REQ-027 DONE SHALL last one cycle with done_o=1, fault_o=(cause_o!=0), and the state SHALL return to IDLE; busy_o SHALL be 0 from IDLE onward.
REQ-028 rdata_o SHALL be the addressed lane right-shifted, then sign- or zero-extended per size_i/unsigned_i; it SHALL be held until the next done_o.
REQ-029 For stores, and whenever fault_o=1, rdata_o SHALL be 0.
REQ-030 Cause codes: 0 none, 1 misaligned, 2 bus error, 3 timeout, 4 retry exhausted, 5 aborted, 6 illegal size.

Reset
REQ-031 rst_i=1 SHALL immediately force IDLE and drive cyc_o, stb_o, we_o, busy_o, done_o and fault_o to 0, and adr_o, sel_o, dat_o, rdata_o and cause_o to 0, including during an active bus cycle.
REQ-032 The retry and timeout counters SHALL clear on reset, and the first edge after release SHALL sample req_i normally.

Structure
REQ-033 Package lsu_pkg SHALL hold the state encoding, size codes and cause codes.
REQ-034 Lane select, shift and extension logic SHALL be in combinational sub-module lsu_align, parametrised by DATA_WIDTH.

Verification
REQ-035 Load byte, unsigned_i=0, addr 0x1003, dat_i=0x80FF_FF00 -> sel_o=4'b1000, rdata_o=0xFFFF_FF80, done_o one cycle after ack_i.
REQ-036 Store half to 0x2002, wdata 0x1234 -> sel_o=4'b1100, dat_o=0x1234_0000, we_o=1; word at 0x2001 -> no cyc_o, cause 1.
REQ-037 MAX_RETRY=2, rty_i on 3 consecutive issues -> 3 cyc_o assertions each separated by 1 idle cycle, then cause 4.
REQ-038 No response, TIMEOUT=8 -> cyc_o high 8 cycles, then cause 3.
REQ-039 ack_i and err_i in the same cycle -> success; abort_i in cycle 2 of REQ -> cyc_o low next cycle, cause 5.
REQ-040 DATA_WIDTH=64, load dword at 0x8 -> sel_o=8'hFF; rst_i pulsed mid-REQ -> cyc_o=0 asynchronously, IDLE afterwards.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the Wishbone load/store unit: FSM states, access sizes,
// completion cause codes and the alignment check.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_MISALIGN = 3'd1,
    CAUSE_BUS_ERR  = 3'd2,
    CAUSE_TIMEOUT  = 3'd3,
    CAUSE_RETRY    = 3'd4,
    CAUSE_ABORT    = 3'd5,
    CAUSE_ILL_SIZE = 3'd6
  } cause_e;

  // Natural alignment: an access of 2^size bytes must start on a 2^size boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo[1:0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store side builds sel/shifted data from the live request,
// load side extracts the addressed lane and sign/zero-extends it.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int NB = DATA_WIDTH / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [1:0]            st_size_i,
  input  logic [OW-1:0]         st_off_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [NB-1:0]         sel_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [1:0]            ld_size_i,
  input  logic [OW-1:0]         ld_off_i,
  input  logic                  ld_uns_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] ld_o
);

  logic [NB-1:0]         st_mask;
  logic [DATA_WIDTH-1:0] ld_sh;
  logic                  ld_sign;
  int                    ld_bits;

  always_comb begin
    st_mask = '0;
    for (int j = 0; j < NB; j++) begin
      st_mask[j] = (j < (1 << st_size_i));
    end
  end

  assign sel_o = st_mask << st_off_i;
  assign dat_o = wdata_i << {st_off_i, 3'b000};
  assign ld_sh = rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_bits = DATA_WIDTH;
    ld_sign = ld_sh[DATA_WIDTH-1];
    case (ld_size_i)
      SZ_BYTE: begin ld_bits = 8;  ld_sign = ld_sh[7];  end
      SZ_HALF: begin ld_bits = 16; ld_sign = ld_sh[15]; end
      SZ_WORD: begin ld_bits = 32; ld_sign = ld_sh[31]; end
      default: ;
    endcase
    ld_o = ld_sh;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      if (b >= ld_bits) ld_o[b] = ld_sign & ~ld_uns_i;
    end
  end

endmodule

// File: rtl/lsu_wb.sv
// Single-outstanding Wishbone master for core loads/stores with retry back-off,
// timeout, abort and alignment faults reported through cause_o.
module lsu_wb
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_RETRY  = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [1:0]              size_i,
  input  logic                    unsigned_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    abort_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    fault_o,
  output logic [2:0]              cause_o,
  output logic                    cyc_o,
  output logic                    stb_o,
  output logic                    we_o,
  output logic [ADDR_WIDTH-1:0]   adr_o,
  output logic [DATA_WIDTH/8-1:0] sel_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic                    ack_i,
  input  logic                    err_i,
  input  logic                    rty_i
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int TW = $clog2(TIMEOUT + 2);

  state_e                state_q, state_d;
  cause_e                cause_q, cause_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [RW-1:0]         rty_q, rty_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  we_q, uns_q;
  logic [1:0]            size_q;
  logic [OW-1:0]         off_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [NB-1:0]         sel_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  latch_req;

  logic [NB-1:0]         st_sel;
  logic [DATA_WIDTH-1:0] st_dat;
  logic [DATA_WIDTH-1:0] ld_data;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .st_size_i (size_i),
    .st_off_i  (addr_i[OW-1:0]),
    .wdata_i   (wdata_i),
    .sel_o     (st_sel),
    .dat_o     (st_dat),
    .ld_size_i (size_q),
    .ld_off_i  (off_q),
    .ld_uns_i  (uns_q),
    .rdata_i   (dat_i),
    .ld_o      (ld_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cause_q <= CAUSE_NONE;
      rdata_q <= '0;
      rty_q   <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      rdata_q <= rdata_d;
      rty_q   <= rty_d;
      tmo_q   <= tmo_d;
      if (latch_req) begin
        we_q   <= we_i;
        uns_q  <= unsigned_i;
        size_q <= size_i;
        off_q  <= addr_i[OW-1:0];
        adr_q  <= {addr_i[ADDR_WIDTH-1:OW], {OW{1'b0}}};
        sel_q  <= st_sel;
        dat_q  <= st_dat;
      end
    end
  end

  // Response priority in REQ: ack > err > rty > abort > timeout.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    rdata_d   = rdata_q;
    rty_d     = rty_q;
    tmo_d     = tmo_q;
    latch_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          latch_req = 1'b1;
          rty_d     = '0;
          tmo_d     = '0;
          if ((DATA_WIDTH < 64) && (size_i == SZ_DWORD)) begin
            state_d = ST_DONE;
            cause_d = CAUSE_ILL_SIZE;
            rdata_d = '0;
          end else if (is_misaligned(size_i, addr_i[2:0])) begin
            state_d = ST_DONE;
            cause_d = CAUSE_MISALIGN;
            rdata_d = '0;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (ack_i) begin
          state_d = ST_DONE;
          cause_d = CAUSE_NONE;
          rdata_d = we_q ? '0 : ld_data;
        end else if (err_i) begin
          state_d = ST_DONE;
          cause_d = CAUSE_BUS_ERR;
          rdata_d = '0;
        end else if (rty_i) begin
          if (rty_q == RW'(MAX_RETRY)) begin
            state_d = ST_DONE;
            cause_d = CAUSE_RETRY;
            rdata_d = '0;
          end else begin
            state_d = ST_BACKOFF;
            rty_d   = rty_q + 1'b1;
          end
        end else if (abort_i) begin
          state_d = ST_DONE;
          cause_d = CAUSE_ABORT;
          rdata_d = '0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_DONE;
          cause_d = CAUSE_TIMEOUT;
          rdata_d = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_BACKOFF: begin
        if (abort_i) begin
          state_d = ST_DONE;
          cause_d = CAUSE_ABORT;
          rdata_d = '0;
        end else begin
          state_d = ST_REQ;
          tmo_d   = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cyc_o   = (state_q == ST_REQ);
    stb_o   = (state_q == ST_REQ);
    busy_o  = (state_q != ST_IDLE);
    done_o  = (state_q == ST_DONE);
    fault_o = (cause_q != CAUSE_NONE);
    cause_o = cause_q;
    rdata_o = rdata_q;
    we_o    = we_q;
    adr_o   = adr_q;
    sel_o   = sel_q;
    dat_o   = dat_q;
  end

endmodule

// File: tb/tb_lsu_wb.sv
// Directed bench for lsu_wb: a 32-bit instance (MAX_RETRY=2, TIMEOUT=8) with a
// result scoreboard, plus a 64-bit instance for the dword path.
module tb_lsu_wb;

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  cause;
  } exp_t;

  exp_t sbq[$];
  int   nvec = 0;
  int   nerr = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req, we, uns, abort, ack, err, rty;
  logic [1:0]  size;
  logic [31:0] addr, wdata, dat_i;
  logic        busy, done, fault, cyc, stb, we_o;
  logic [2:0]  cause;
  logic [31:0] rdata, adr, dat_o;
  logic [3:0]  sel;

  logic        w_req, w_ack;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [63:0] w_dat_i;
  logic        w_busy, w_done, w_fault, w_cyc, w_stb, w_we_o;
  logic [2:0]  w_cause;
  logic [63:0] w_rdata, w_dat_o;
  logic [31:0] w_adr;
  logic [7:0]  w_sel;

  lsu_wb #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_RETRY(2), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size),
    .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata), .abort_i(abort),
    .busy_o(busy), .done_o(done), .rdata_o(rdata), .fault_o(fault), .cause_o(cause),
    .cyc_o(cyc), .stb_o(stb), .we_o(we_o), .adr_o(adr), .sel_o(sel), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack), .err_i(err), .rty_i(rty)
  );

  lsu_wb #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MAX_RETRY(3), .TIMEOUT(255)) dut64 (
    .clk_i(clk), .rst_i(rst), .req_i(w_req), .we_i(1'b0), .size_i(w_size),
    .unsigned_i(1'b0), .addr_i(w_addr), .wdata_i(64'd0), .abort_i(1'b0),
    .busy_o(w_busy), .done_o(w_done), .rdata_o(w_rdata), .fault_o(w_fault), .cause_o(w_cause),
    .cyc_o(w_cyc), .stb_o(w_stb), .we_o(w_we_o), .adr_o(w_adr), .sel_o(w_sel), .dat_o(w_dat_o),
    .dat_i(w_dat_i), .ack_i(w_ack), .err_i(1'b0), .rty_i(1'b0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one request for a single cycle and records its expected result.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic [2:0] ec);
    sbq.push_back('{rdata: er, cause: ec});
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    exp_t e;
    int   n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, done, 1);
    if (sbq.size() == 0) begin
      nvec++;
      nerr++;
      $error("FAIL %s_sbq: observed empty scoreboard expected one entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_rdata"}, rdata, e.rdata);
      chk({tag, "_cause"}, cause, e.cause);
      chk({tag, "_fault"}, fault, (e.cause != 3'd0));
      @(negedge clk);
      chk({tag, "_pulse"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_hold"}, rdata, e.rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    req = 0; we = 0; uns = 0; abort = 0; ack = 0; err = 0; rty = 0;
    size = 0; addr = 0; wdata = 0; dat_i = 0;
    w_req = 0; w_ack = 0; w_size = 0; w_addr = 0; w_dat_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_done", done, 0);
    chk("rst_cause", cause, 0);
    chk("rst_sel", sel, 0);
    rst = 1'b0;
    @(negedge clk);

    // Signed byte load from the top lane.
    issue(0, 2'd0, 0, 32'h1003, 0, 32'hFFFF_FF80, 3'd0);
    chk("ldb_cyc", cyc, 1);
    chk("ldb_stb", stb, 1);
    chk("ldb_sel", sel, 4'b1000);
    chk("ldb_adr", adr, 32'h1000);
    chk("ldb_we", we_o, 0);
    chk("ldb_busy", busy, 1);
    ack = 1; dat_i = 32'h80FF_FF00;
    @(negedge clk);
    ack = 0;
    chk("ldb_cyc_drop", cyc, 0);
    wait_done("ldb", 0);

    // Half store to the upper half.
    issue(1, 2'd1, 0, 32'h2002, 32'h0000_1234, 32'h0, 3'd0);
    chk("sth_sel", sel, 4'b1100);
    chk("sth_dat", dat_o, 32'h1234_0000);
    chk("sth_we", we_o, 1);
    chk("sth_adr", adr, 32'h2000);
    ack = 1; dat_i = 32'hDEAD_BEEF;
    @(negedge clk);
    ack = 0;
    wait_done("sth", 0);

    // Misaligned word and illegal dword never reach the bus.
    issue(0, 2'd2, 0, 32'h2001, 0, 32'h0, 3'd1);
    chk("mis_cyc", cyc, 0);
    wait_done("mis", 0);
    issue(0, 2'd3, 0, 32'h0010, 0, 32'h0, 3'd6);
    chk("ill_cyc", cyc, 0);
    wait_done("ill", 0);

    // Retry exhaustion: three issues separated by one back-off cycle each.
    issue(0, 2'd2, 0, 32'h3000, 0, 32'h0, 3'd4);
    for (int k = 0; k < 3; k++) begin
      chk("rty_cyc_on", cyc, 1);
      rty = 1;
      @(negedge clk);
      rty = 0;
      if (k < 2) begin
        chk("rty_backoff", cyc, 0);
        @(negedge clk);
      end
    end
    wait_done("rty", 0);

    // Timeout with no response.
    issue(0, 2'd2, 0, 32'h4000, 0, 32'h0, 3'd3);
    n = 0;
    while (cyc === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_cycles", n, 8);
    wait_done("tmo", 0);

    // ack wins over a simultaneous err.
    issue(0, 2'd2, 1, 32'h5004, 0, 32'hCAFE_F00D, 3'd0);
    ack = 1; err = 1; dat_i = 32'hCAFE_F00D;
    @(negedge clk);
    ack = 0; err = 0;
    wait_done("ackerr", 0);

    // Half loads, zero- and sign-extended, and a positive byte.
    issue(0, 2'd1, 1, 32'h6002, 0, 32'h0000_9ABC, 3'd0);
    @(negedge clk);
    ack = 1; dat_i = 32'h9ABC_1111;
    @(negedge clk);
    ack = 0;
    wait_done("lhu", 0);
    issue(0, 2'd1, 0, 32'h6002, 0, 32'hFFFF_9ABC, 3'd0);
    ack = 1; dat_i = 32'h9ABC_1111;
    @(negedge clk);
    ack = 0;
    wait_done("lh", 0);
    issue(0, 2'd0, 0, 32'h6001, 0, 32'h0000_007F, 3'd0);
    ack = 1; dat_i = 32'h0000_7F00;
    @(negedge clk);
    ack = 0;
    wait_done("lb_pos", 0);

    // Abort: ignored in IDLE, honoured in REQ, ignored alongside ack.
    abort = 1;
    @(negedge clk);
    chk("abort_idle", busy, 0);
    abort = 0;
    issue(0, 2'd2, 0, 32'h7000, 0, 32'h0, 3'd5);
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_cyc", cyc, 0);
    wait_done("abort", 0);
    issue(0, 2'd2, 0, 32'h7100, 0, 32'h1122_3344, 3'd0);
    ack = 1; abort = 1; dat_i = 32'h1122_3344;
    @(negedge clk);
    ack = 0; abort = 0;
    wait_done("abort_ack", 0);

    // Reset in the middle of a bus cycle.
    req = 1; we = 0; size = 2'd2; addr = 32'h7200;
    @(negedge clk);
    req = 0;
    chk("rst_mid_cyc_on", cyc, 1);
    #2 rst = 1;
    #1;
    chk("rst_mid_cyc", cyc, 0);
    chk("rst_mid_stb", stb, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_adr", adr, 0);
    chk("rst_mid_sel", sel, 0);
    chk("rst_mid_rdata", rdata, 0);
    @(negedge clk);
    rst = 0;
    issue(0, 2'd2, 0, 32'h7300, 0, 32'h55AA_55AA, 3'd0);
    chk("post_rst_cyc", cyc, 1);
    ack = 1; dat_i = 32'h55AA_55AA;
    @(negedge clk);
    ack = 0;
    wait_done("post_rst", 0);

    // 64-bit instance: aligned dword load.
    w_req = 1; w_size = 2'd3; w_addr = 32'h8;
    @(negedge clk);
    w_req = 0;
    chk("dw_sel", w_sel, 8'hFF);
    chk("dw_adr", w_adr, 32'h8);
    chk("dw_cyc", w_cyc, 1);
    chk("dw_stb", w_stb, 1);
    chk("dw_busy", w_busy, 1);
    chk("dw_we", w_we_o, 0);
    chk("dw_dat_o", w_dat_o, 64'd0);
    w_ack = 1; w_dat_i = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    w_ack = 0;
    chk("dw_done", w_done, 1);
    chk("dw_rdata", w_rdata, 64'h0123_4567_89AB_CDEF);
    chk("dw_cause", w_cause, 0);
    chk("dw_fault", w_fault, 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
